// File: rtl/serial_pkg.sv
// Shared definitions for the SmartCargo serial link (7 data bits, odd parity).
// Also imported by the smart_cargo receiver, so keep it transmitter-agnostic.
package serial_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Parity bit that makes the total count of ones (data + parity) odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/serial_tx_7o1_if.sv
// Host-side write port of the serial transmitter: word, strobe and flow-control flags.
interface serial_tx_7o1_if;
  import serial_pkg::*;

  logic [DATA_BITS-1:0] dado;
  logic                 envia;
  logic                 pronto;
  logic                 overflow;

  modport master (output dado, output envia, input pronto, input overflow);
  modport slave  (input dado, input envia, output pronto, output overflow);

endinterface

// File: rtl/serial_tx_fifo.sv
// Small synchronous show-ahead FIFO for queued transmit words.
// Pointers wrap naturally, so DEPTH must be a power of two.
module serial_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [6:0] wr_data,
  input  logic       rd_en,
  output logic [6:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [6:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = wr_en & ~full;
  assign w_pop   = rd_en & ~empty;
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage holds data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/serial_tx_7o1.sv
// SmartCargo serial transmitter: start, 7 data bits LSB first, odd parity, stop.
// TX is registered from next-state values so the line changes exactly on state entry.
module serial_tx_7o1
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  serial_tx_7o1_if.slave   bus,
  output logic             TX,
  output logic             ocupado
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  state_t                 r_state, w_state_n;
  logic [BAUD_W-1:0]      r_baud, w_baud_n;
  logic [2:0]             r_bit, w_bit_n;
  logic [DATA_BITS-1:0]   r_shift, w_shift_n;
  logic                   r_par, w_par_n;
  logic                   r_tx, w_tx_n;
  logic                   r_ocupado, w_ocupado_n;
  logic                   r_overflow;
  logic                   w_full, w_empty, w_pop, w_wr_acc, w_baud_end;
  logic [DATA_BITS-1:0]   w_fifo_data;

  serial_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.envia),
    .wr_data (bus.dado),
    .rd_en   (w_pop),
    .rd_data (w_fifo_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign bus.pronto   = ~w_full;
  assign bus.overflow = r_overflow;
  assign TX           = r_tx;
  assign ocupado      = r_ocupado;
  assign w_wr_acc     = bus.envia & ~w_full;
  assign w_baud_end   = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud + 1'b1;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_par_n   = r_par;
    w_pop     = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_n = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_fifo_data;
          w_par_n   = odd_parity(w_fifo_data);
          w_state_n = START;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = DATA;
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          if (r_bit == 3'd6) begin
            w_state_n = PARITY;
          end else begin
            w_bit_n   = r_bit + 1'b1;
            w_shift_n = r_shift >> 1;
          end
        end
      end
      PARITY: begin
        if (w_baud_end) begin
          w_baud_n  = '0;
          w_state_n = STOP;
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_baud_n = '0;
          // Chain straight into the next frame so queued words go out without an idle gap.
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_fifo_data;
            w_par_n   = odd_parity(w_fifo_data);
            w_state_n = START;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: begin
        w_baud_n  = '0;
        w_state_n = IDLE;
      end
    endcase

    case (w_state_n)
      START:   w_tx_n = 1'b0;
      DATA:    w_tx_n = w_shift_n[0];
      PARITY:  w_tx_n = w_par_n;
      default: w_tx_n = 1'b1;
    endcase

    // Any pop implies leaving for START, so a non-empty FIFO or a fresh write keeps us busy.
    w_ocupado_n = (w_state_n != IDLE) | ~w_empty | w_wr_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_tx       <= 1'b1;
      r_ocupado  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_baud     <= w_baud_n;
      r_bit      <= w_bit_n;
      r_tx       <= w_tx_n;
      r_ocupado  <= w_ocupado_n;
      // Flags the cycle after a write was refused because the FIFO was full.
      r_overflow <= bus.envia & w_full;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_n;
    r_par   <= w_par_n;
  end

endmodule
